// File: rtl/tile_pixel_fetch.sv
// Tile-map pixel source: screen coordinate + scroll -> map entry -> pattern row -> palette,
// one RGB565 result per request, six cycles after the request edge.
module tile_pixel_fetch #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          MAP_COLS = 80,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [9:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [9:0]  scroll_x,
  input  logic [8:0]  scroll_y,
  output logic        map_ren,
  output logic [12:0] map_addr,
  input  logic [15:0] map_rdata,
  output logic        pat_ren,
  output logic [10:0] pat_addr,
  input  logic [31:0] pat_rdata,
  output logic        pal_ren,
  output logic [7:0]  pal_addr,
  input  logic [15:0] pal_rdata,
  output logic        pix_valid,
  output logic [15:0] pix_color
);

  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
  localparam logic [12:0] COLS13 = 13'(MAP_COLS);

  // Out-of-range coordinates and scrolls collapse to 0; the sum wraps once.
  function automatic logic [10:0] wrap_pos(input logic [10:0] pos, input logic [10:0] scr,
                                           input logic [10:0] lim);
    logic [10:0] p, s, sum;
    p   = (pos >= lim) ? 11'd0 : pos;
    s   = (scr >= lim) ? 11'd0 : scr;
    sum = p + s;
    if (sum >= lim) sum = sum - lim;
    return sum;
  endfunction

  logic        vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, vld_p5_q, pix_valid_q;
  logic        vld_p0_d, vld_p1_d, vld_p2_d, vld_p3_d, vld_p4_d, vld_p5_d, pix_valid_d;
  logic [12:0] map_addr_q, map_addr_d;
  logic [10:0] pat_addr_q, pat_addr_d;
  logic [7:0]  pal_addr_q, pal_addr_d;
  logic [15:0] pix_color_q, pix_color_d;

  logic [2:0]  fx_p0_q, fy_p0_q, fx_p1_q, fy_p1_q, fx_p2_q, fx_p3_q;
  logic [2:0]  fx_p0_d, fy_p0_d, fx_p1_d, fy_p1_d, fx_p2_d, fx_p3_d;
  logic [3:0]  bank_p2_q, bank_p3_q, bank_p2_d, bank_p3_d;
  logic        hflip_p2_q, hflip_p3_q, hflip_p2_d, hflip_p3_d;
  logic        tpen_p2_q, tpen_p3_q, tpen_p2_d, tpen_p3_d;
  logic        tp_p4_q, tp_p5_q, tp_p4_d, tp_p5_d;

  logic [10:0] wx, wy;
  logic [2:0]  col;
  logic [3:0]  nib;
  logic        unused_bits;

  assign unused_bits = ^{map_rdata[15], wx[10], wy[10:9]};

  always_comb begin
    // Stage 0: coordinate wrap and map address
    wx         = wrap_pos({1'b0, req_x}, {1'b0, scroll_x}, H_LIM);
    wy         = wrap_pos({2'b00, req_y}, {2'b00, scroll_y}, V_LIM);
    vld_p0_d   = req_valid;
    map_addr_d = map_addr_q;
    if (req_valid) map_addr_d = {7'd0, wy[8:3]} * COLS13 + {6'd0, wx[9:3]};
    fx_p0_d    = wx[2:0];
    fy_p0_d    = wy[2:0];

    vld_p1_d = vld_p0_q;
    fx_p1_d  = fx_p0_q;
    fy_p1_d  = fy_p0_q;

    // Stage 2: map entry arrives, pattern row address (vflip mirrors the row)
    vld_p2_d   = vld_p1_q;
    pat_addr_d = pat_addr_q;
    if (vld_p1_q) pat_addr_d = {map_rdata[7:0], fy_p1_q ^ {3{map_rdata[13]}}};
    fx_p2_d    = fx_p1_q;
    bank_p2_d  = map_rdata[11:8];
    hflip_p2_d = map_rdata[12];
    tpen_p2_d  = map_rdata[14];

    vld_p3_d   = vld_p2_q;
    fx_p3_d    = fx_p2_q;
    bank_p3_d  = bank_p2_q;
    hflip_p3_d = hflip_p2_q;
    tpen_p3_d  = tpen_p2_q;

    // Stage 4: pattern row arrives, pick the nibble, palette address
    col        = fx_p3_q ^ {3{hflip_p3_q}};
    nib        = pat_rdata[{col, 2'b00} +: 4];
    vld_p4_d   = vld_p3_q;
    pal_addr_d = pal_addr_q;
    if (vld_p3_q) pal_addr_d = {bank_p3_q, nib};
    tp_p4_d    = tpen_p3_q & (nib == 4'd0);

    vld_p5_d = vld_p4_q;
    tp_p5_d  = tp_p4_q;

    // Stage 6: colour out
    pix_valid_d = vld_p5_q;
    pix_color_d = pix_color_q;
    if (vld_p5_q) pix_color_d = tp_p5_q ? BG_COLOR : pal_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      vld_p4_q    <= 1'b0;
      vld_p5_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      map_addr_q  <= '0;
      pat_addr_q  <= '0;
      pal_addr_q  <= '0;
      pix_color_q <= '0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      vld_p4_q    <= vld_p4_d;
      vld_p5_q    <= vld_p5_d;
      pix_valid_q <= pix_valid_d;
      map_addr_q  <= map_addr_d;
      pat_addr_q  <= pat_addr_d;
      pal_addr_q  <= pal_addr_d;
      pix_color_q <= pix_color_d;
    end
  end

  // Side-band data rides with the valid bits and needs no reset.
  always_ff @(posedge clk) begin
    fx_p0_q    <= fx_p0_d;
    fy_p0_q    <= fy_p0_d;
    fx_p1_q    <= fx_p1_d;
    fy_p1_q    <= fy_p1_d;
    fx_p2_q    <= fx_p2_d;
    bank_p2_q  <= bank_p2_d;
    hflip_p2_q <= hflip_p2_d;
    tpen_p2_q  <= tpen_p2_d;
    fx_p3_q    <= fx_p3_d;
    bank_p3_q  <= bank_p3_d;
    hflip_p3_q <= hflip_p3_d;
    tpen_p3_q  <= tpen_p3_d;
    tp_p4_q    <= tp_p4_d;
    tp_p5_q    <= tp_p5_d;
  end

  assign map_ren   = vld_p0_q;
  assign map_addr  = map_addr_q;
  assign pat_ren   = vld_p2_q;
  assign pat_addr  = pat_addr_q;
  assign pal_ren   = vld_p4_q;
  assign pal_addr  = pal_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_color = pix_color_q;

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Bench for tile_pixel_fetch: behavioural memories and colour model, per-cycle compare,
// directed literal lookups, streams with a mid-stream reset, and randomized traffic.
module tb_tile_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [9:0]  req_x = '0;
  logic [8:0]  req_y = '0;
  logic [9:0]  scroll_x = '0;
  logic [8:0]  scroll_y = '0;
  logic        map_ren, pat_ren, pal_ren, pix_valid;
  logic [12:0] map_addr;
  logic [10:0] pat_addr;
  logic [7:0]  pal_addr;
  logic [15:0] map_rdata, pal_rdata, pix_color;
  logic [31:0] pat_rdata;

  logic [15:0] map_mem [0:4799];
  logic [31:0] pat_mem [0:2047];
  logic [15:0] pal_mem [0:255];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [15:0] color;
  } exp_t;
  exp_t        q[$];
  logic        exp_mren = 1'b0;
  int          exp_maddr_v = 0;
  logic [15:0] last_color = 16'h0000;

  tile_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .map_ren(map_ren), .map_addr(map_addr), .map_rdata(map_rdata),
    .pat_ren(pat_ren), .pat_addr(pat_addr), .pat_rdata(pat_rdata),
    .pal_ren(pal_ren), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
    .pix_valid(pix_valid), .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (map_ren) map_rdata <= map_mem[map_addr];
    if (pat_ren) pat_rdata <= pat_mem[pat_addr];
    if (pal_ren) pal_rdata <= pal_mem[pal_addr];
  end

  function automatic int wrapc(int p, int s, int lim);
    if (p >= lim) p = 0;
    if (s >= lim) s = 0;
    return (p + s) % lim;
  endfunction

  function automatic int model_maddr(int x, int y, int sx, int sy);
    return (wrapc(y, sy, 480) / 8) * 80 + wrapc(x, sx, 640) / 8;
  endfunction

  function automatic logic [15:0] model_color(int x, int y, int sx, int sy);
    int wx, wy, row, colm, nib;
    logic [15:0] e;
    logic [31:0] pat;
    wx   = wrapc(x, sx, 640);
    wy   = wrapc(y, sy, 480);
    e    = map_mem[(wy / 8) * 80 + wx / 8];
    row  = e[13] ? 7 - (wy % 8) : wy % 8;
    pat  = pat_mem[int'(e[7:0]) * 8 + row];
    colm = e[12] ? 7 - (wx % 8) : wx % 8;
    nib  = int'((pat >> (4 * colm)) & 32'hF);
    if (e[14] && nib == 0) return 16'h0000;
    return pal_mem[int'(e[11:8]) * 16 + nib];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: every accepted request becomes an expected result six edges later.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
      exp_mren = 1'b0;
    end else begin
      exp_mren = req_valid;
      if (req_valid) begin
        e.due   = cyc + 6;
        e.color = model_color(int'(req_x), int'(req_y), int'(scroll_x), int'(scroll_y));
        q.push_back(e);
        exp_maddr_v = model_maddr(int'(req_x), int'(req_y), int'(scroll_x), int'(scroll_y));
      end
    end
  end

  always @(negedge clk) begin
    logic ev;
    if (!rst_n) begin
      q.delete();
      last_color = 16'h0000;
      chk("reset_ctrl", {60'd0, pix_valid, map_ren, pat_ren, pal_ren}, 64'd0);
      chk("reset_data", {16'd0, map_addr, pat_addr, pal_addr, pix_color}, 64'd0);
    end else begin
      chk("map_ren", {63'd0, map_ren}, {63'd0, exp_mren});
      if (exp_mren) chk("map_addr", {51'd0, map_addr}, 64'(exp_maddr_v));
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("pix_valid", {63'd0, pix_valid}, {63'd0, ev});
      if (ev) begin
        chk("pix_color", {48'd0, pix_color}, {48'd0, q[0].color});
        last_color = q[0].color;
        void'(q.pop_front());
      end else begin
        chk("color_hold", {48'd0, pix_color}, {48'd0, last_color});
      end
    end
  end

  task automatic single(input int x, input int y, input int sx, input int sy,
                        input int em, input int ep, input int epal, input logic [15:0] ecol);
    @(negedge clk);
    req_valid = 1'b1;
    req_x = 10'(x); req_y = 9'(y); scroll_x = 10'(sx); scroll_y = 9'(sy);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lit_map_addr", {51'd0, map_addr}, 64'(em));
    repeat (2) @(negedge clk);
    chk("lit_pat_addr", {52'd0, pat_ren, pat_addr}, {52'd1, 11'(ep)});
    repeat (2) @(negedge clk);
    chk("lit_pal_addr", {55'd0, pal_ren, pal_addr}, {55'd1, 8'(epal)});
    repeat (2) @(negedge clk);
    chk("lit_color", {47'd0, pix_valid, pix_color}, {47'd1, ecol});
    @(negedge clk);
  endtask

  task automatic stream(input int n, input int y);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_x = 10'(i); req_y = 9'(y); scroll_x = '0; scroll_y = '0;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4800; i++) map_mem[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) pat_mem[i] = $urandom;
    for (int i = 0; i < 256; i++)  pal_mem[i] = 16'($urandom);

    // Reset held with a live request, then released with the request still asserted.
    req_valid = 1'b1; req_x = 10'd100; req_y = 9'd50;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);

    map_mem[161] = 16'h0305; pat_mem[45] = 32'h87654321; pat_mem[42] = 32'h87654321;
    pal_mem[8'h36] = 16'hF800; pal_mem[8'h33] = 16'h07E0;
    single(13, 21, 0, 0, 161, 45, 8'h36, 16'hF800);
    map_mem[161] = 16'h1305;
    single(13, 21, 0, 0, 161, 45, 8'h33, 16'h07E0);
    map_mem[161] = 16'h2305;
    single(13, 21, 0, 0, 161, 42, 8'h36, 16'hF800);
    map_mem[161] = 16'h3305;
    single(13, 21, 0, 0, 161, 42, 8'h33, 16'h07E0);
    map_mem[161] = 16'h4305; pat_mem[45] = 32'h87054321; pal_mem[8'h30] = 16'h1234;
    single(13, 21, 0, 0, 161, 45, 8'h30, 16'h0000);
    map_mem[161] = 16'h0305;
    single(13, 21, 0, 0, 161, 45, 8'h30, 16'h1234);

    map_mem[1] = 16'h0305;
    single(630, 470, 20, 15, 1, 45, 8'h33, 16'h07E0);
    map_mem[960] = 16'h0305; pat_mem[44] = 32'h11111111; pal_mem[8'h31] = 16'hABCD;
    single(700, 100, 0, 0, 960, 44, 8'h31, 16'hABCD);
    map_mem[4799] = 16'h0305; pat_mem[47] = 32'h90000000; pal_mem[8'h39] = 16'h5555;
    single(639, 479, 0, 0, 4799, 47, 8'h39, 16'h5555);
    map_mem[0] = 16'h0305; pat_mem[40] = 32'h00000002; pal_mem[8'h32] = 16'h0F0F;
    single(639, 479, 1, 1, 0, 40, 8'h32, 16'h0F0F);

    stream(20, 33);
    repeat (8) @(negedge clk);

    // Stream interrupted by reset at request 10; in-flight requests must vanish.
    stream(10, 34);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stream(10, 35);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 9) < 7);
      req_x     = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 639));
      req_y     = ($urandom_range(0, 3) == 0) ? 9'($urandom)  : 9'($urandom_range(0, 479));
      scroll_x  = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'($urandom_range(0, 639));
      scroll_y  = ($urandom_range(0, 4) == 0) ? 9'($urandom)  : 9'($urandom_range(0, 479));
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
